// File: rtl/sqm_ones_sched_pkg.sv
// Shared types and widths for the square-mod / ones-run scheduler.
package sqm_ones_pkg;

    localparam int A_W = 8;
    localparam int B_W = 4;
    localparam int Z_W = 4;

    localparam logic OP_SQMOD = 1'b1;
    localparam logic OP_ONES  = 1'b0;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESP} sched_state_t;

    typedef struct packed {
        logic           op;
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
    } cmd_t;

    // A square-mod command with a zero modulus never reaches the datapath result.
    function automatic logic is_div_zero(input cmd_t c);
        return (c.op == OP_SQMOD) && (c.a == '0);
    endfunction

endpackage

// File: rtl/sqm_ones_sched_if.sv
// Request, datapath and response signals of the scheduler; slave = scheduler side.
interface sqm_ones_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
);
    import sqm_ones_pkg::*;

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     req_op;
    logic [A_W*NUM_REQ-1:0] req_a;
    logic [B_W*NUM_REQ-1:0] req_b;

    logic                   dp_op;
    logic [A_W-1:0]         dp_a;
    logic [B_W-1:0]         dp_b;
    logic [A_W-1:0]         dp_y;
    logic [Z_W-1:0]         dp_z;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [A_W-1:0]         rsp_y;
    logic [Z_W-1:0]         rsp_z;
    logic                   rsp_err;
    logic                   busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, dp_y, dp_z, rsp_ready,
        output req_ready, dp_op, dp_a, dp_b, rsp_valid, rsp_id, rsp_y, rsp_z, rsp_err, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, dp_y, dp_z, rsp_ready,
        input  req_ready, dp_op, dp_a, dp_b, rsp_valid, rsp_id, rsp_y, rsp_z, rsp_err, busy
    );

endinterface

// File: rtl/sqm_ones_sched_rr_arbiter.sv
// Round-robin pick of the first valid requester at or after rr_ptr; zero latency.
// No backpressure of its own: grant is a pure function of req_valid and rr_ptr.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req_valid,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);

    logic found;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req_valid[j] && (((int'(rr_ptr) + k) % N) == j)) begin
                    found     = 1'b1;
                    grant_idx = ID_W'(j);
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            grant[k] = found && (grant_idx == ID_W'(k));
        end
    end

endmodule

// File: rtl/sqm_ones_sched.sv
// Shares one square-mod/ones-run datapath between NUM_REQ requesters; response SETTLE_CYCLES+1 edges after accept (div-by-zero: on the accept edge).
// One command in flight; req_ready stays low until the response handshake completes, and rsp_* hold while rsp_ready is low.
module sqm_ones_sched
    import sqm_ones_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    sqm_ones_sched_if.slave  bus
);

    sched_state_t     state, state_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_q;
    logic [2:0]       cnt;
    cmd_t             dp_q;
    cmd_t             cmd_g;
    logic             accept;
    logic [A_W-1:0]   rsp_y_q;
    logic [Z_W-1:0]   rsp_z_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic             rsp_err_q;

    rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);

    always_comb begin
        cmd_g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                cmd_g.op = bus.req_op[i];
                cmd_g.a  = bus.req_a[i*A_W +: A_W];
                cmd_g.b  = bus.req_b[i*B_W +: B_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = is_div_zero(cmd_g) ? RESP : SETTLE;
            SETTLE:  if (cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            cnt       <= '0;
            dp_q      <= '0;
            rsp_y_q   <= '0;
            rsp_z_q   <= '0;
            rsp_id_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dp_q   <= cmd_g;
                        id_q   <= grant_idx;
                        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        if (is_div_zero(cmd_g)) begin
                            rsp_err_q <= 1'b1;
                            rsp_y_q   <= '0;
                            rsp_z_q   <= '0;
                            rsp_id_q  <= grant_idx;
                        end else begin
                            cnt <= 3'(SETTLE_CYCLES - 1);
                        end
                    end
                end
                SETTLE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                CAPTURE: begin
                    rsp_y_q   <= bus.dp_y;
                    rsp_z_q   <= bus.dp_z;
                    rsp_err_q <= 1'b0;
                    rsp_id_q  <= id_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.dp_op     = dp_q.op;
    assign bus.dp_a      = dp_q.a;
    assign bus.dp_b      = dp_q.b;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_sqm_ones_sched.sv
// Bench for sqm_ones_sched: SETTLE_CYCLES=1 instance with scoreboard, SETTLE_CYCLES=4 instance for reset abort.
module tb_sqm_ones_sched;

    logic clk = 1'b0;
    logic rst_n;
    logic rst4_n;

    always #5 clk = ~clk;

    sqm_ones_sched_if #(.NUM_REQ(2), .ID_W(1)) b1 ();
    sqm_ones_sched_if #(.NUM_REQ(2), .ID_W(1)) b4 ();

    sqm_ones_sched #(.NUM_REQ(2), .SETTLE_CYCLES(1), .ID_W(1)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .bus (b1)
    );
    sqm_ones_sched #(.NUM_REQ(2), .SETTLE_CYCLES(4), .ID_W(1)) u_dut4 (
        .clk (clk), .rst_n (rst4_n), .bus (b4)
    );

    // External datapath: op=1 -> B*B mod A, op=0 -> A passed through; Z = longest ones run of Y.
    function automatic logic [7:0] ref_y(input logic op, input logic [7:0] a, input logic [3:0] b);
        if (!op) return a;
        if (a == 8'd0) return 8'd0;
        return 8'((16'(b) * 16'(b)) % 16'(a));
    endfunction

    function automatic logic [3:0] ones_run(input logic [7:0] y);
        int run = 0;
        int best = 0;
        for (int i = 0; i < 8; i++) begin
            run  = y[i] ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        return 4'(best);
    endfunction

    assign b1.dp_y = ref_y(b1.dp_op, b1.dp_a, b1.dp_b);
    assign b1.dp_z = ones_run(b1.dp_y);
    assign b4.dp_y = ref_y(b4.dp_op, b4.dp_a, b4.dp_b);
    assign b4.dp_z = ones_run(b4.dp_y);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       id;
        logic [7:0] y;
        logic [3:0] z;
        logic       err;
        int         due;
    } exp_t;

    exp_t sb[$];
    logic got_ids[$];
    int   cyc = 0;
    int   mptr = 0;
    logic prev_vld = 1'b0;

    // Scoreboard monitor for the SETTLE_CYCLES=1 instance, sampled on the falling edge.
    always @(negedge clk) begin : mon
        int   g;
        logic op_g;
        logic [7:0] a_g;
        logic [3:0] b_g;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            mptr = 0;
            sb.delete();
            prev_vld = 1'b0;
        end else begin
            if ((b1.req_valid & b1.req_ready) != 2'b00) begin
                g = -1;
                for (int k = 0; k < 2; k++)
                    if (g < 0 && b1.req_valid[(mptr + k) % 2]) g = (mptr + k) % 2;
                chk("grant", 32'(b1.req_ready), 32'(1 << g));
                op_g = 1'b0; a_g = 8'd0; b_g = 4'd0;
                for (int j = 0; j < 2; j++) begin
                    if (j == g) begin
                        op_g = b1.req_op[j];
                        a_g  = b1.req_a[j*8 +: 8];
                        b_g  = b1.req_b[j*4 +: 4];
                    end
                end
                e.id  = g[0];
                e.err = op_g && (a_g == 8'd0);
                e.y   = e.err ? 8'd0 : ref_y(op_g, a_g, b_g);
                e.z   = e.err ? 4'd0 : ones_run(e.y);
                // Seen one falling edge after the rising edge where rsp_valid rises:
                // normal = SETTLE_CYCLES+1 edges after accept, error = the accept edge itself.
                e.due = cyc + (e.err ? 1 : 3);
                sb.push_back(e);
                mptr = (g + 1) % 2;
            end
            if (b1.rsp_valid && !prev_vld) begin
                if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
                else                chk("latency", cyc, sb[0].due);
            end
            if (b1.rsp_valid && b1.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_no_cmd", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id",  32'(b1.rsp_id),  32'(e.id));
                    chk("rsp_y",   32'(b1.rsp_y),   32'(e.y));
                    chk("rsp_z",   32'(b1.rsp_z),   32'(e.z));
                    chk("rsp_err", 32'(b1.rsp_err), 32'(e.err));
                    got_ids.push_back(b1.rsp_id);
                end
            end
            prev_vld = b1.rsp_valid;
        end
    end

    task automatic send(input int idx, input logic op, input logic [7:0] a, input logic [3:0] b);
        logic ok = 1'b0;
        b1.req_op[idx]        = op;
        b1.req_a[idx*8 +: 8]  = a;
        b1.req_b[idx*4 +: 4]  = b;
        b1.req_valid[idx]     = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = b1.req_ready[idx];
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        b1.req_valid[idx] = 1'b0;
    endtask

    // Returns on the falling edge where the response handshake is visible.
    task automatic wait_rsp();
        logic ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = b1.rsp_valid && b1.rsp_ready;
        end
        if (!ok) chk("rsp_timeout", 0, 1);
    endtask

    initial begin
        logic ok;
        int   k;
        rst_n = 1'b0; rst4_n = 1'b0;
        b1.req_valid = 2'b11; b1.req_op = '0; b1.req_a = '0; b1.req_b = '0; b1.rsp_ready = 1'b1;
        b4.req_valid = 2'b00; b4.req_op = '0; b4.req_a = '0; b4.req_b = '0; b4.rsp_ready = 1'b1;

        // Reset state, with requests present that must not be acknowledged.
        @(negedge clk);
        chk("rst_req_ready", 32'(b1.req_ready), 0);
        chk("rst_rsp_valid", 32'(b1.rsp_valid), 0);
        chk("rst_busy",      32'(b1.busy), 0);
        chk("rst_dp_a",      32'(b1.dp_a), 0);
        chk("rst_rsp_y",     32'(b1.rsp_y), 0);
        b1.req_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1; rst4_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 32'(b1.req_ready), 0);
        chk("idle_busy",      32'(b1.busy), 0);
        @(posedge clk); #1;

        // Square-mod: 5*5 mod 7 = 4.
        send(0, 1'b1, 8'd7, 4'd5);
        wait_rsp();
        chk("sqmod_y",  32'(b1.rsp_y), 32'h04);
        chk("sqmod_z",  32'(b1.rsp_z), 32'd1);
        chk("sqmod_id", 32'(b1.rsp_id), 32'd0);
        @(posedge clk); #1;

        // Ones-run pass-through from requester 1.
        send(1, 1'b0, 8'hFF, 4'b1000);
        @(negedge clk);
        chk("ones_dp_op", 32'(b1.dp_op), 0);
        chk("ones_dp_a",  32'(b1.dp_a), 32'hFF);
        chk("ones_dp_b",  32'(b1.dp_b), 32'h8);
        wait_rsp();
        chk("ones_y",  32'(b1.rsp_y), 32'hFF);
        chk("ones_z",  32'(b1.rsp_z), 32'd8);
        chk("ones_id", 32'(b1.rsp_id), 32'd1);
        @(posedge clk); #1;

        // Modulo by zero: short path, error flagged, results zeroed.
        send(0, 1'b1, 8'd0, 4'd3);
        chk("divz_busy", 32'(b1.busy), 1);
        wait_rsp();
        chk("divz_err", 32'(b1.rsp_err), 1);
        chk("divz_y",   32'(b1.rsp_y), 0);
        chk("divz_z",   32'(b1.rsp_z), 0);
        @(posedge clk); #1;

        // Backpressure while requester 0 is waiting.
        b1.rsp_ready = 1'b0;
        b1.req_op[0] = 1'b0; b1.req_a[7:0] = 8'h33; b1.req_b[3:0] = 4'd0;
        send(1, 1'b0, 8'h0F, 4'd0);
        b1.req_valid[0] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = b1.rsp_valid;
        end
        if (!ok) chk("bp_rsp_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid",     32'(b1.rsp_valid), 1);
            chk("bp_y",         32'(b1.rsp_y), 32'h0F);
            chk("bp_z",         32'(b1.rsp_z), 32'd4);
            chk("bp_req_ready", 32'(b1.req_ready), 0);
            chk("bp_busy",      32'(b1.busy), 1);
        end
        @(posedge clk); #1;
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_no_accept", 32'(b1.req_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_back_idle",  32'(b1.busy), 0);
        chk("bp_next_grant", 32'(b1.req_ready), 32'b01);
        @(posedge clk); #1;
        b1.req_valid[0] = 1'b0;
        wait_rsp();
        @(posedge clk); #1;

        // Arbitration: both requesters held valid from reset.
        rst_n = 1'b0;
        b1.req_valid = 2'b11;
        b1.req_op = 2'b00; b1.req_a = 16'h5A3C; b1.req_b = '0;
        @(negedge clk);
        chk("arb_rst_ready", 32'(b1.req_ready), 0);
        got_ids.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        k = 0;
        while (got_ids.size() < 4 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        b1.req_valid = 2'b00;
        chk("arb_count", 32'(got_ids.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_ids.size()) chk("arb_order", 32'(got_ids[i]), 32'(i % 2));
        end
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 0);

        // Reset in the middle of SETTLE on the SETTLE_CYCLES=4 instance.
        b4.req_op[0] = 1'b1; b4.req_a[7:0] = 8'd7; b4.req_b[3:0] = 4'd5;
        b4.req_valid[0] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = b4.req_ready[0];
        end
        if (!ok) chk("s4_accept_timeout", 0, 1);
        @(posedge clk); #1;
        b4.req_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("s4_pre_dp_a", 32'(b4.dp_a), 32'd7);
        chk("s4_pre_busy", 32'(b4.busy), 1);
        rst4_n = 1'b0;
        #1;
        chk("s4_rst_valid", 32'(b4.rsp_valid), 0);
        chk("s4_rst_busy",  32'(b4.busy), 0);
        chk("s4_rst_dp_a",  32'(b4.dp_a), 0);
        chk("s4_rst_dp_b",  32'(b4.dp_b), 0);
        chk("s4_rst_dp_op", 32'(b4.dp_op), 0);
        b4.req_valid = 2'b11;
        b4.req_b[7:4] = 4'd2; b4.req_a[15:8] = 8'd9; b4.req_op[1] = 1'b0;
        @(negedge clk);
        chk("s4_rst_ready", 32'(b4.req_ready), 0);
        @(posedge clk); #1;
        rst4_n = 1'b1;
        @(negedge clk);
        chk("s4_first_grant", 32'(b4.req_ready), 32'b01);
        @(posedge clk); #1;
        b4.req_valid = 2'b00;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 30) begin
            @(negedge clk);
            k++;
            ok = b4.rsp_valid;
        end
        // Accept edge + 5 edges (4 SETTLE + CAPTURE); first seen on the 6th falling edge.
        chk("s4_latency", 32'(k), 32'd6);
        chk("s4_y",  32'(b4.rsp_y), 32'h04);
        chk("s4_z",  32'(b4.rsp_z), 32'd1);
        chk("s4_id", 32'(b4.rsp_id), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s4_done_busy", 32'(b4.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
